mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit: the consumer of the EX/MEM pipeline register outputs.
//  - Turns the registered load/store controls plus Result (address) and WriteData into data-memory bus transactions.
//  - Bus uses a req/ready handshake. Stores get byte enables for SB/SH; loads are extracted and sign/zero-extended for LB/LBU/LH/LHU.
//  - Holds the pipeline with stall until each access completes.

---
 rtl/mem_stage_lsu_pkg.sv | 33 +++
 rtl/mem_stage_lsu_if.sv | 22 ++
 rtl/mem_stage_lsu_align.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Access size of the operation in flight.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Byte-enable patterns for lane 0; shifted up by the byte offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_aligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_HALF: return ~off[0];
      SZ_WORD: return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Lane steering: store byte enables and replicated write data, and
// extraction plus sign/zero extension of load data from a bus word.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       off_i,
  input  size_e            size_i,
  input  logic             unsigned_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [3:0]       be_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic [WIDTH-1:0] load_o
);

  logic [WIDTH-1:0] shifted;

  // Bring the addressed byte/half down to lane 0.
  assign shifted = rdata_i >> {off_i, 3'b000};

  // Per-size enables, store replication and load extension.
  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    load_o  = shifted;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE << off_i;
        wdata_o = {(WIDTH/8){wdata_i[7:0]}};
        load_o  = unsigned_i ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                             : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = BE_HALF << off_i;
        wdata_o = {(WIDTH/16){wdata_i[15:0]}};
        load_o  = unsigned_i ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                             : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // Words are always aligned, so shifted equals rdata_i here.
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        load_o  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into bus
// transactions and holds the pipeline until each access completes.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_to_reg_i,
  input  logic             mem_write_i,
  input  logic             lb_i,
  input  logic             lbu_i,
  input  logic             lh_i,
  input  logic             lhu_i,
  input  logic             sb_i,
  input  logic             sh_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic             kill_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] load_data_o,
  output logic             done_o,
  output logic             misalign_o,
  mem_stage_lsu_if.master  dm
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] load_data_q;
  logic [3:0]       be_q;
  logic             we_q;
  size_e            size_q;
  logic             uns_q;
  logic [1:0]       off_q;

  logic             op;
  logic             is_store;
  size_e            in_size;
  logic             in_uns;
  logic             in_aligned;
  logic             latch_en;
  logic             capture_en;
  logic             req;

  logic             use_live;
  size_e            al_size;
  logic [1:0]       al_off;
  logic             al_uns;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] al_load;

  // Store wins when both controls are set.
  assign op         = mem_to_reg_i | mem_write_i;
  assign is_store   = mem_write_i;
  assign in_uns     = ~is_store & (lbu_i | lhu_i);
  assign in_aligned = is_aligned(in_size, result_i[1:0]);

  // Decode access size of the incoming op.
  always_comb begin
    in_size = SZ_WORD;
    if (is_store) begin
      if (sb_i)      in_size = SZ_BYTE;
      else if (sh_i) in_size = SZ_HALF;
    end else begin
      if (lb_i | lbu_i)      in_size = SZ_BYTE;
      else if (lh_i | lhu_i) in_size = SZ_HALF;
    end
  end

  // One aligner serves both the REQ latch (live inputs, in IDLE) and the
  // LoadData capture (latched size/offset, in REQ).
  assign use_live = (state_q == ST_IDLE);
  assign al_size  = use_live ? in_size : size_q;
  assign al_off   = use_live ? result_i[1:0] : off_q;
  assign al_uns   = use_live ? in_uns : uns_q;

  mem_stage_lsu_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .off_i      (al_off),
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .wdata_i    (write_data_i),
    .rdata_i    (dm.rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .load_o     (al_load)
  );

  // Next state and handshake outputs; IDLE outputs are gated by reset so
  // everything reads zero while rst_n is low.
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    misalign_o = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && op && !kill_i) begin
          if (in_aligned) begin
            stall_o  = 1'b1;
            latch_en = 1'b1;
            state_d  = ST_REQ;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (dm.ready) begin
          // A kill arriving with the completion squashes the result.
          if (kill_i) begin
            state_d = ST_IDLE;
          end else begin
            capture_en = ~we_q;
            state_d    = ST_DONE;
          end
        end else if (kill_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_o = 1'b1;
        if (dm.ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request fields and captured load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_WORD;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q  <= {result_i[WIDTH-1:2], 2'b00};
        be_q    <= is_store ? al_be : BE_WORD;
        wdata_q <= is_store ? al_wdata : '0;
        we_q    <= is_store;
        size_q  <= in_size;
        uns_q   <= in_uns;
        off_q   <= result_i[1:0];
      end
      if (capture_en) load_data_q <= al_load;
    end
  end

  assign req         = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign dm.req      = req;
  assign dm.we       = we_q & req;
  assign dm.addr     = addr_q;
  assign dm.be       = be_q;
  assign dm.wdata    = wdata_q;
  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed spec scenarios plus
// randomized transactions checked against a behavioural model.
module tb_mem_stage_lsu;

  localparam int W     = 32;
  localparam int K_LW  = 0;
  localparam int K_LH  = 1;
  localparam int K_LHU = 2;
  localparam int K_LB  = 3;
  localparam int K_LBU = 4;
  localparam int K_SW  = 5;
  localparam int K_SH  = 6;
  localparam int K_SB  = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_to_reg, mem_write, lb, lbu, lh, lhu, sb, sh;
  logic [W-1:0] result, write_data;
  logic         kill;
  logic         stall, done, misalign;
  logic [W-1:0] load_data;

  int errors = 0;
  int checks = 0;

  mem_stage_lsu_if #(.WIDTH(W)) dm_if ();

  mem_stage_lsu #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_to_reg_i (mem_to_reg),
    .mem_write_i  (mem_write),
    .lb_i         (lb),
    .lbu_i        (lbu),
    .lh_i         (lh),
    .lhu_i        (lhu),
    .sb_i         (sb),
    .sh_i         (sh),
    .result_i     (result),
    .write_data_i (write_data),
    .kill_i       (kill),
    .stall_o      (stall),
    .load_data_o  (load_data),
    .done_o       (done),
    .misalign_o   (misalign),
    .dm           (dm_if)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit exp_misal(input int kind, input logic [31:0] a);
    if (kind == K_LH || kind == K_LHU || kind == K_SH) return (a % 2) != 0;
    if (kind == K_LW || kind == K_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input int kind, input logic [31:0] a);
    int s;
    s = int'(a % 4);
    if (kind == K_SB) return 4'(1 << s);
    if (kind == K_SH) return 4'(3 << s);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input int kind, input logic [31:0] d);
    if (kind == K_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (kind == K_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input int kind, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = rd >> (8 * (a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (kind)
      K_LB:    return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
      K_LBU:   return b;
      K_LH:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      K_LHU:   return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int kind, input logic [31:0] a, input logic [31:0] d);
    mem_to_reg = (kind < K_SW);
    mem_write  = (kind >= K_SW);
    lb         = (kind == K_LB);
    lbu        = (kind == K_LBU);
    lh         = (kind == K_LH);
    lhu        = (kind == K_LHU);
    sb         = (kind == K_SB);
    sh         = (kind == K_SH);
    result     = a;
    write_data = d;
  endtask

  task automatic clear_op();
    mem_to_reg = 0; mem_write = 0;
    lb = 0; lbu = 0; lh = 0; lhu = 0; sb = 0; sh = 0;
    result = '0; write_data = '0;
  endtask

  // Drives one op through its full lifetime and checks every cycle.
  task automatic run_txn(input int kind, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int waits);
    bit          mis;
    logic [3:0]  ebe;
    logic [31:0] ew;
    logic [31:0] el;
    logic [31:0] ea;
    mis = exp_misal(kind, a);
    ebe = exp_be(kind, a);
    ew  = exp_wdata(kind, d);
    el  = exp_load(kind, a, rd);
    ea  = a & 32'hFFFF_FFFC;
    @(negedge clk);
    set_op(kind, a, d); kill = 0; dm_if.ready = 0; #1;
    checks++;
    if (mis) begin
      if (misalign !== 1'b1 || stall !== 1'b0 || dm_if.req !== 1'b0) begin
        errors++;
        $display("FAIL misalign_pulse kind=%0d addr=%h: misalign=%b stall=%b req=%b, need 1 0 0",
                 kind, a, misalign, stall, dm_if.req);
      end
      @(negedge clk); clear_op(); #1;
      checks++;
      if (misalign !== 1'b0 || stall !== 1'b0 || dm_if.req !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL misalign_after kind=%0d addr=%h: misalign=%b stall=%b req=%b done=%b, need 0 0 0 0",
                 kind, a, misalign, stall, dm_if.req, done);
      end
      $display("txn kind=%0d addr=%h misaligned", kind, a);
      return;
    end
    if (stall !== 1'b1 || dm_if.req !== 1'b0 || misalign !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL accept kind=%0d addr=%h: stall=%b req=%b misalign=%b done=%b, need 1 0 0 0",
               kind, a, stall, dm_if.req, misalign, done);
    end
    for (int c = 0; c <= waits; c++) begin
      @(negedge clk); #1;
      checks++;
      if (dm_if.req !== 1'b1 || stall !== 1'b1 || done !== 1'b0 || dm_if.addr !== ea ||
          dm_if.be !== ebe || dm_if.we !== (kind >= K_SW)) begin
        errors++;
        $display("FAIL req_phase kind=%0d cyc=%0d: req=%b stall=%b done=%b addr=%h be=%b we=%b, need 1 1 0 %h %b %b",
                 kind, c, dm_if.req, stall, done, dm_if.addr, dm_if.be, dm_if.we,
                 ea, ebe, (kind >= K_SW));
      end
      if (kind >= K_SW) begin
        checks++;
        if (dm_if.wdata !== ew) begin
          errors++;
          $display("FAIL store_wdata kind=%0d: wdata=%h, need %h", kind, dm_if.wdata, ew);
        end
      end
      dm_if.ready = (c == waits);
      dm_if.rdata = rd;
    end
    @(negedge clk); dm_if.ready = 0; #1;
    checks++;
    if (done !== 1'b1 || stall !== 1'b0 || dm_if.req !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse kind=%0d: done=%b stall=%b req=%b, need 1 0 0",
               kind, done, stall, dm_if.req);
    end
    if (kind < K_SW) begin
      checks++;
      if (load_data !== el) begin
        errors++;
        $display("FAIL load_data kind=%0d addr=%h: got %h, need %h", kind, a, load_data, el);
      end
    end
    @(negedge clk); clear_op(); #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || dm_if.req !== 1'b0) begin
      errors++;
      $display("FAIL after_done kind=%0d: done=%b stall=%b req=%b, need 0 0 0",
               kind, done, stall, dm_if.req);
    end
    $display("txn kind=%0d addr=%h wdata=%h rdata=%h waits=%0d load=%h",
             kind, a, d, rd, waits, load_data);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // An op presented during reset must not leak through.
    set_op(K_SW, 32'h104, 32'h1);
    #1;
    checks++;
    if (stall !== 0 || done !== 0 || misalign !== 0 || dm_if.req !== 0 || dm_if.we !== 0 ||
        dm_if.be !== 4'b0 || load_data !== '0 || dm_if.addr !== '0 || dm_if.wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b done=%b mis=%b req=%b we=%b be=%b ld=%h addr=%h wd=%h, need all 0",
               stall, done, misalign, dm_if.req, dm_if.we, dm_if.be, load_data,
               dm_if.addr, dm_if.wdata);
    end
    @(negedge clk); clear_op(); rst_n = 1; #1;
    checks++;
    if (stall !== 0 || dm_if.req !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_release: stall=%b req=%b done=%b, need 0 0 0", stall, dm_if.req, done);
    end
    $display("txn reset");
  endtask

  task automatic test_store_word();
    run_txn(K_SW, 32'h104, 32'hDEAD_BEEF, 32'h0, 0);
    checks++;
    if (dm_if.addr !== 32'h104 || dm_if.be !== 4'b1111 || dm_if.wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_fields: addr=%h be=%b wdata=%h, need 00000104 1111 deadbeef",
               dm_if.addr, dm_if.be, dm_if.wdata);
    end
  endtask

  task automatic test_store_byte();
    run_txn(K_SB, 32'h103, 32'h0000_00A5, 32'h0, 0);
    checks++;
    if (dm_if.be !== 4'b1000 || dm_if.wdata !== 32'hA5A5_A5A5 || dm_if.addr !== 32'h100) begin
      errors++;
      $display("FAIL sb_fields: be=%b wdata=%h addr=%h, need 1000 a5a5a5a5 00000100",
               dm_if.be, dm_if.wdata, dm_if.addr);
    end
    run_txn(K_SH, 32'h102, 32'h1234_BEEF, 32'h0, 1);
  endtask

  task automatic test_loads();
    run_txn(K_LB, 32'h200, 32'h0, 32'h80F1_7F82, 0);
    checks++;
    if (load_data !== 32'hFFFF_FF82) begin
      errors++; $display("FAIL lb_value: got %h, need ffffff82", load_data);
    end
    run_txn(K_LBU, 32'h200, 32'h0, 32'h80F1_7F82, 0);
    checks++;
    if (load_data !== 32'h0000_0082) begin
      errors++; $display("FAIL lbu_value: got %h, need 00000082", load_data);
    end
    run_txn(K_LH, 32'h202, 32'h0, 32'h80F1_7F82, 0);
    checks++;
    if (load_data !== 32'hFFFF_80F1) begin
      errors++; $display("FAIL lh_value: got %h, need ffff80f1", load_data);
    end
    run_txn(K_LHU, 32'h202, 32'h0, 32'h80F1_7F82, 0);
    checks++;
    if (load_data !== 32'h0000_80F1) begin
      errors++; $display("FAIL lhu_value: got %h, need 000080f1", load_data);
    end
    run_txn(K_LW, 32'h204, 32'h0, 32'h80F1_7F82, 0);
  endtask

  task automatic test_wait_states();
    run_txn(K_SW, 32'h340, 32'h0BAD_F00D, 32'h0, 4);
    run_txn(K_LB, 32'h341, 32'h0, 32'h0000_F700, 4);
  endtask

  task automatic test_misalign();
    run_txn(K_LH, 32'h201, 32'h0, 32'h0, 0);
    run_txn(K_SW, 32'h102, 32'h5, 32'h0, 0);
    run_txn(K_LW, 32'h103, 32'h0, 32'h0, 0);
    run_txn(K_SH, 32'h101, 32'h7, 32'h0, 0);
    run_txn(K_LHU, 32'h203, 32'h0, 32'h0, 0);
  endtask

  task automatic test_kill();
    // Known LoadData before the squashed load.
    run_txn(K_LW, 32'h300, 32'h0, 32'h1234_5678, 0);
    @(negedge clk); set_op(K_LW, 32'h304, 32'h0); dm_if.ready = 0; #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL kill_accept: stall=%b, need 1", stall);
    end
    @(negedge clk); #1;
    checks++;
    if (dm_if.req !== 1'b1) begin
      errors++; $display("FAIL kill_req: req=%b, need 1", dm_if.req);
    end
    kill = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); clear_op(); kill = 0; #1;
      checks++;
      if (dm_if.req !== 1'b1 || stall !== 1'b1 || done !== 1'b0 || dm_if.addr !== 32'h304) begin
        errors++;
        $display("FAIL drain_hold cyc=%0d: req=%b stall=%b done=%b addr=%h, need 1 1 0 00000304",
                 c, dm_if.req, stall, done, dm_if.addr);
      end
      if (c == 1) begin
        dm_if.ready = 1; dm_if.rdata = 32'hCAFE_F00D;
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); dm_if.ready = 0; #1;
      checks++;
      if (dm_if.req !== 0 || done !== 0 || stall !== 0 || load_data !== 32'h1234_5678) begin
        errors++;
        $display("FAIL drain_end cyc=%0d: req=%b done=%b stall=%b ld=%h, need 0 0 0 12345678",
                 c, dm_if.req, done, stall, load_data);
      end
    end
    $display("txn kill during REQ");
    // kill in IDLE suppresses both a legal and a misaligned op.
    @(negedge clk); set_op(K_SW, 32'h400, 32'h9); kill = 1; #1;
    checks++;
    if (stall !== 0 || misalign !== 0) begin
      errors++; $display("FAIL kill_idle_sw: stall=%b misalign=%b, need 0 0", stall, misalign);
    end
    @(negedge clk); set_op(K_LH, 32'h201, 32'h0); #1;
    checks++;
    if (stall !== 0 || misalign !== 0 || dm_if.req !== 0) begin
      errors++;
      $display("FAIL kill_idle_lh: stall=%b misalign=%b req=%b, need 0 0 0", stall, misalign, dm_if.req);
    end
    @(negedge clk); clear_op(); kill = 0; #1;
    checks++;
    if (dm_if.req !== 0 || done !== 0) begin
      errors++; $display("FAIL kill_idle_after: req=%b done=%b, need 0 0", dm_if.req, done);
    end
    $display("txn kill in IDLE");
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk); set_op(K_SW, 32'h500, 32'h1122_3344); #1;
    @(negedge clk); #1;
    checks++;
    if (dm_if.req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: req=%b, need 1", dm_if.req);
    end
    #2; rst_n = 0; #1;
    checks++;
    if (stall !== 0 || done !== 0 || misalign !== 0 || dm_if.req !== 0 || dm_if.we !== 0 ||
        dm_if.be !== 4'b0 || load_data !== '0 || dm_if.addr !== '0 || dm_if.wdata !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: stall=%b done=%b mis=%b req=%b we=%b be=%b ld=%h addr=%h wd=%h, need all 0",
               stall, done, misalign, dm_if.req, dm_if.we, dm_if.be, load_data,
               dm_if.addr, dm_if.wdata);
    end
    @(negedge clk); clear_op(); rst_n = 1; #1;
    @(negedge clk); #1;
    checks++;
    if (dm_if.req !== 0 || stall !== 0 || done !== 0) begin
      errors++;
      $display("FAIL rst_mid_after: req=%b stall=%b done=%b, need 0 0 0", dm_if.req, stall, done);
    end
    $display("txn reset during REQ");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 7));
      a    = $urandom;
      run_txn(kind, a, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    clear_op();
    kill        = 0;
    dm_if.ready = 0;
    dm_if.rdata = '0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_wait_states();
    test_misalign();
    test_kill();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
